nes_pad_poller: RTL and testbench

Sequencer for the NES controller port. It runs the pad's latch/clock protocol once per request, typically the per-frame `frame_end` pulse. It deserialises the 8 active-low button bits and presents a registered, active-high button word plus a newly-pressed mask. It drives the `uio_out[1:0]` latch/clock pins and feeds the input controller in place of the direct `ui_in` button mapping.

---
 rtl/nes_pad_poller.sv | 134 +++++++++++++
 tb/tb_nes_pad_poller.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_poller.sv
// NES controller port sequencer: latch/clock protocol, serial capture,
// registered active-high button word with a newly-pressed mask.
module nes_pad_poller #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_LO    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [15:0] LAT  = 16'(LATCH_CYCLES);
  localparam logic [15:0] HALF = 16'(HALF_CYCLES);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        s1;
  logic        s2;
  logic        last;
  logic [7:0]  word;

  // Counter is loaded with the phase length; a phase ends when it reads 1.
  assign last = (cnt == 16'd1);

  // Completed word including the bit 7 being sampled on the final edge.
  always_comb begin
    word    = shift;
    word[7] = ~s2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      pressed   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1    <= nes_data;
      s2    <= s1;
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (poll) begin
            state     <= S_LATCH;
            cnt       <= LAT;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LATCH: begin
          if (last) begin
            state     <= S_GAP;
            cnt       <= HALF;
            nes_latch <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_GAP: begin
          if (last) begin
            shift[0] <= ~s2;
            idx      <= 3'd1;
            state    <= S_HI;
            cnt      <= HALF;
            nes_clk  <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_HI: begin
          if (last) begin
            state   <= S_LO;
            cnt     <= HALF;
            nes_clk <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_LO: begin
          if (last) begin
            shift[idx] <= ~s2;
            if (idx == 3'd7) begin
              buttons <= word;
              pressed <= word & ~buttons;
              valid   <= 1'b1;
              state   <= S_DONE;
              cnt     <= '0;
            end else begin
              idx     <= idx + 3'd1;
              state   <= S_HI;
              cnt     <= HALF;
              nes_clk <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench: pad shift-register model, small-parameter instance
// plus a default-parameter instance for full-length timing.
module tb_nes_pad_poller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll = 1'b0;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       busy;

  logic       d_poll = 1'b0;
  logic       d_latch;
  logic       d_clk;
  logic [7:0] d_buttons;
  logic [7:0] d_pressed;
  logic       d_valid;
  logic       d_busy;

  int vecs = 0;
  int errs = 0;

  logic [7:0] pad_val = 8'h00;
  logic [7:0] pr = 8'hFF;
  logic       absent = 1'b0;
  logic       clk_q = 1'b0;

  always #5 clk = ~clk;

  nes_pad_poller #(.LATCH_CYCLES(4), .HALF_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .poll(poll), .nes_data(nes_data),
    .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
    .pressed(pressed), .valid(valid), .busy(busy)
  );

  nes_pad_poller dut_def (
    .clk(clk), .rst_n(rst_n), .poll(d_poll), .nes_data(1'b1),
    .nes_latch(d_latch), .nes_clk(d_clk), .buttons(d_buttons),
    .pressed(d_pressed), .valid(d_valid), .busy(d_busy)
  );

  // Pad: parallel load while latched, shift on clock rise, 1 fed in.
  always @(negedge clk) begin
    if (nes_latch) pr = ~pad_val;
    else if (nes_clk && !clk_q) pr = {1'b1, pr[7:1]};
    clk_q = nes_clk;
  end
  assign nes_data = absent ? 1'b1 : pr[0];

  task automatic run_poll(input logic [7:0] btn, output int vedge,
                          output int lw, output int rises, output int hi);
    logic pc;
    int n;
    pad_val = btn;
    poll = 1'b1;
    @(posedge clk); #1;
    poll = 1'b0;
    n = 1;
    lw = nes_latch ? 1 : 0;
    rises = 0;
    hi = 0;
    pc = nes_clk;
    vedge = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (nes_latch) lw++;
      if (nes_clk && !pc) rises++;
      if (nes_clk) hi++;
      pc = nes_clk;
      if (valid) begin
        vedge = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({nes_latch, nes_clk, valid, busy} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 0000",
               {nes_latch, nes_clk, valid, busy});
    end
    vecs++;
    if ({buttons, pressed} !== 16'h0) begin
      errs++;
      $display("FAIL reset_word: got %h want 0000", {buttons, pressed});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int v, lw, r, h;
    run_poll(8'h88, v, lw, r, h);
    vecs++;
    if (lw !== 4) begin
      errs++; $display("FAIL basic_latch_w: got %0d want 4", lw);
    end
    vecs++;
    if (r !== 7) begin
      errs++; $display("FAIL basic_clk_rises: got %0d want 7", r);
    end
    vecs++;
    if (h !== 14) begin
      errs++; $display("FAIL basic_clk_high: got %0d want 14", h);
    end
    vecs++;
    if (v !== 35) begin
      errs++; $display("FAIL basic_valid_edge: got %0d want 35", v);
    end
    vecs++;
    if (buttons !== 8'h88 || pressed !== 8'h88) begin
      errs++;
      $display("FAIL basic_word: got %h/%h want 88/88", buttons, pressed);
    end
    vecs++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL basic_busy_done: got %b want 1", busy);
    end
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_idle: got busy %b valid %b want 0 0", busy, valid);
    end
  endtask

  task automatic test_edge;
    int v, lw, r, h;
    run_poll(8'h09, v, lw, r, h);
    vecs++;
    if (buttons !== 8'h09 || pressed !== 8'h01) begin
      errs++;
      $display("FAIL edge_first: got %h/%h want 09/01", buttons, pressed);
    end
    repeat (2) @(posedge clk);
    #1;
    run_poll(8'h09, v, lw, r, h);
    vecs++;
    if (buttons !== 8'h09 || pressed !== 8'h00) begin
      errs++;
      $display("FAIL edge_repeat: got %h/%h want 09/00", buttons, pressed);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_ignore;
    int rises, first_v, second_l, vcnt;
    logic pl;
    rises = 0; first_v = -1; second_l = -1; vcnt = 0; pl = 1'b0;
    pad_val = 8'h09;
    poll = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (n == 50) poll = 1'b0;
      if (nes_latch && !pl) begin
        rises++;
        if (rises == 2) second_l = n;
      end
      pl = nes_latch;
      if (valid) begin
        vcnt++;
        if (first_v < 0) first_v = n;
      end
    end
    vecs++;
    if (rises !== 2 || vcnt !== 2) begin
      errs++;
      $display("FAIL held_count: got %0d latches %0d valids want 2 2",
               rises, vcnt);
    end
    vecs++;
    if (first_v !== 35 || second_l !== 37) begin
      errs++;
      $display("FAIL held_restart: got valid %0d relatch %0d want 35 37",
               first_v, second_l);
    end
    rises = 0; vcnt = 0; pl = 1'b0;
    poll = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      poll = (n == 5);
      if (nes_latch && !pl) rises++;
      pl = nes_latch;
      if (valid) vcnt++;
    end
    poll = 1'b0;
    vecs++;
    if (rises !== 1 || vcnt !== 1) begin
      errs++;
      $display("FAIL gap_poll: got %0d latches %0d valids want 1 1",
               rises, vcnt);
    end
  endtask

  task automatic test_absent;
    int v, lw, r, h;
    absent = 1'b1;
    run_poll(8'h5A, v, lw, r, h);
    absent = 1'b0;
    vecs++;
    if (v !== 35) begin
      errs++; $display("FAIL absent_valid: got %0d want 35", v);
    end
    vecs++;
    if (buttons !== 8'h00 || pressed !== 8'h00) begin
      errs++;
      $display("FAIL absent_word: got %h/%h want 00/00", buttons, pressed);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int v, lw, r, h;
    run_poll(8'h3C, v, lw, r, h);
    vecs++;
    if (buttons !== 8'h3C || pressed !== 8'h3C) begin
      errs++;
      $display("FAIL pre_reset: got %h/%h want 3c/3c", buttons, pressed);
    end
    repeat (2) @(posedge clk);
    #1;
    pad_val = 8'h42;
    poll = 1'b1;
    @(posedge clk); #1;
    poll = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    vecs++;
    if (nes_clk !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_hi: got clk %b busy %b want 1 1", nes_clk, busy);
    end
    rst_n = 1'b0;
    poll = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    poll = 1'b0;
    vecs++;
    if ({nes_latch, nes_clk, valid, busy, buttons, pressed} !== 20'h0) begin
      errs++;
      $display("FAIL mid_reset: got %b %h %h want 0000 00 00",
               {nes_latch, nes_clk, valid, busy}, buttons, pressed);
    end
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL reset_no_start: got busy %b want 0", busy);
    end
    run_poll(8'hFF, v, lw, r, h);
    vecs++;
    if (lw !== 4 || v !== 35) begin
      errs++;
      $display("FAIL post_reset_timing: got lw %0d v %0d want 4 35", lw, v);
    end
    vecs++;
    if (buttons !== 8'hFF || pressed !== 8'hFF) begin
      errs++;
      $display("FAIL post_reset: got %h/%h want ff/ff", buttons, pressed);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_defaults;
    int n, lw, v;
    d_poll = 1'b1;
    @(posedge clk); #1;
    d_poll = 1'b0;
    n = 1;
    lw = d_latch ? 1 : 0;
    v = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n++;
      if (d_latch) lw++;
      if (d_valid) begin
        v = n;
        break;
      end
    end
    vecs++;
    if (lw !== 300) begin
      errs++; $display("FAIL def_latch_w: got %0d want 300", lw);
    end
    vecs++;
    if (v !== 2551) begin
      errs++; $display("FAIL def_valid_edge: got %0d want 2551", v);
    end
    vecs++;
    if (d_buttons !== 8'h00) begin
      errs++; $display("FAIL def_word: got %h want 00", d_buttons);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edge;
    test_busy_ignore;
    test_absent;
    test_reset_mid;
    test_defaults;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
